// File: rtl/auto_pilot.sv
// Autonomous wall-following sequencer: decide -> issue -> move -> back off -> re-align.
// Optional AUTO_BARRIER_EN: pulse place_barrier_signal on FORWARD entry after a junction decision.
module auto_pilot #(
    parameter int BACK_TIME    = 750,
    parameter int FWD_TIME     = 375,
    parameter int CNT_W        = 16,
    parameter int MOVE_TIMEOUT = 4000,
    parameter int LEFT_HAND    = 0,
    parameter int JCNT_W       = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic              i_start,
    input  logic [3:0]        i_detector,
    output logic              o_cmd_valid,
    output logic [1:0]        o_cmd_dir,
    input  logic              i_cmd_ready,
    input  logic              i_move_done,
    output logic              o_move_forward,
    output logic              o_move_backward,
    output logic              o_place_barrier_signal,
    output logic              o_fault,
    output logic [JCNT_W-1:0] o_junction_cnt,
    output logic [3:0]        o_out_state
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        DECIDE  = 4'd1,
        ISSUE   = 4'd2,
        MOVING  = 4'd3,
        BACKING = 4'd4,
        FORWARD = 4'd5,
        FAULT   = 4'd6
    } state_t;

    localparam logic [CNT_W-1:0] BACK_LAST = CNT_W'(BACK_TIME - 1);
    localparam logic [CNT_W-1:0] FWD_LAST  = CNT_W'(FWD_TIME - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'((MOVE_TIMEOUT > 0) ? MOVE_TIMEOUT - 1 : 0);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_dir;
    logic [1:0]         w_dir;
    logic [JCNT_W-1:0]  r_jcnt;
    logic               w_front_clr;
    logic               w_left_clr;
    logic               w_right_clr;
    logic               w_junc;
    logic               w_unused_back;

    assign w_front_clr   = ~i_detector[3];
    assign w_left_clr    = ~i_detector[1];
    assign w_right_clr   = ~i_detector[0];
    assign w_unused_back = i_detector[2];
    assign w_junc = (w_front_clr & w_left_clr) | (w_front_clr & w_right_clr) |
                    (w_left_clr & w_right_clr);

    // First clear direction in hand-rule order; back only when all three are blocked.
    always_comb begin
        w_dir = 2'b11;
        if (LEFT_HAND != 0) begin
            if (w_left_clr)        w_dir = 2'b01;
            else if (w_front_clr)  w_dir = 2'b00;
            else if (w_right_clr)  w_dir = 2'b10;
        end else begin
            if (w_right_clr)       w_dir = 2'b10;
            else if (w_front_clr)  w_dir = 2'b00;
            else if (w_left_clr)   w_dir = 2'b01;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next = DECIDE;
            DECIDE:  w_next = ISSUE;
            ISSUE:   if (i_cmd_ready) w_next = MOVING;
            MOVING: begin
                if (i_move_done)
                    w_next = BACKING;
                else if ((MOVE_TIMEOUT != 0) && (r_cnt == TO_LAST))
                    w_next = FAULT;
            end
            BACKING: if (r_cnt == BACK_LAST) w_next = FORWARD;
            FORWARD: if (r_cnt == FWD_LAST) w_next = DECIDE;
            FAULT:   w_next = FAULT;
            default: w_next = IDLE;
        endcase
        if (!i_enable) w_next = IDLE;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // One counter serves as watchdog in MOVING and phase timer in BACKING/FORWARD.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (w_next != r_state)
            r_cnt <= '0;
        else if (r_state == MOVING || r_state == BACKING || r_state == FORWARD)
            r_cnt <= r_cnt + 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_dir <= '0;
        else if (!i_enable)
            r_dir <= '0;
        else if (r_state == DECIDE)
            r_dir <= w_dir;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_jcnt <= '0;
        else if (i_enable && r_state == DECIDE && w_junc && r_jcnt != '1)
            r_jcnt <= r_jcnt + 1'b1;
    end

`ifdef AUTO_BARRIER_EN
    logic r_junc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_junc <= 1'b0;
        else if (!i_enable)
            r_junc <= 1'b0;
        else if (r_state == DECIDE)
            r_junc <= w_junc;
    end

    assign o_place_barrier_signal = (r_state == FORWARD) && (r_cnt == '0) && r_junc;
`else
    assign o_place_barrier_signal = 1'b0;
`endif

    assign o_cmd_valid     = (r_state == ISSUE);
    assign o_cmd_dir       = r_dir;
    assign o_move_forward  = (r_state == FORWARD);
    assign o_move_backward = (r_state == BACKING);
    assign o_fault         = (r_state == FAULT);
    assign o_junction_cnt  = r_jcnt;
    assign o_out_state     = r_state;

endmodule

// File: tb/tb_auto_pilot.sv
// Directed bench for auto_pilot: right-hand and left-hand instances share stimulus and are
// checked every cycle against a phase/countdown model, plus hand-computed literal checks.
module tb_auto_pilot;

    localparam int BT = 4;
    localparam int FT = 2;
    localparam int TO = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b1;
    logic       start = 1'b0;
    logic       cmd_ready = 1'b0;
    logic       move_done = 1'b0;
    logic [3:0] det = 4'b0000;

    logic       v0, f0, b0, p0, fl0;
    logic [1:0] d0;
    logic [7:0] j0;
    logic [3:0] s0;
    logic       v1, f1, b1, p1, fl1;
    logic [1:0] d1;
    logic [1:0] j1;
    logic [3:0] s1;

    int errors = 0;
    int checks = 0;

    auto_pilot #(.BACK_TIME(BT), .FWD_TIME(FT), .CNT_W(16), .MOVE_TIMEOUT(TO),
                 .LEFT_HAND(0), .JCNT_W(8)) u_rh (
        .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_start(start), .i_detector(det),
        .o_cmd_valid(v0), .o_cmd_dir(d0), .i_cmd_ready(cmd_ready), .i_move_done(move_done),
        .o_move_forward(f0), .o_move_backward(b0), .o_place_barrier_signal(p0),
        .o_fault(fl0), .o_junction_cnt(j0), .o_out_state(s0));

    auto_pilot #(.BACK_TIME(BT), .FWD_TIME(FT), .CNT_W(16), .MOVE_TIMEOUT(TO),
                 .LEFT_HAND(1), .JCNT_W(2)) u_lh (
        .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_start(start), .i_detector(det),
        .o_cmd_valid(v1), .o_cmd_dir(d1), .i_cmd_ready(cmd_ready), .i_move_done(move_done),
        .o_move_forward(f1), .o_move_backward(b1), .o_place_barrier_signal(p1),
        .o_fault(fl1), .o_junction_cnt(j1), .o_out_state(s1));

    always #5 clk = ~clk;

    // Model: phase number, cycles remaining in the phase, last decision, junction bookkeeping.
    int m_st[2];
    int m_rem[2];
    int m_dir[2];
    int m_jc[2];
    int m_jmax[2] = '{255, 3};
    bit m_first[2];
    bit m_junc[2];

    function automatic int n_clear(input logic [3:0] d);
        return int'(!d[3]) + int'(!d[1]) + int'(!d[0]);
    endfunction

    // Direction codes: 0 front, 1 left, 2 right, 3 back.
    function automatic int pick(input logic [3:0] d, input bit lh);
        bit clr[3];
        int order[3];
        clr[0] = !d[3];
        clr[1] = !d[1];
        clr[2] = !d[0];
        if (lh) order = '{1, 0, 2};
        else    order = '{2, 0, 1};
        for (int i = 0; i < 3; i++)
            if (clr[order[i]]) return order[i];
        return 3;
    endfunction

    task automatic model_tick();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_st[k] = 0; m_rem[k] = 0; m_dir[k] = 0; m_jc[k] = 0;
                m_first[k] = 0; m_junc[k] = 0;
            end else if (!enable) begin
                m_st[k] = 0; m_rem[k] = 0; m_dir[k] = 0; m_first[k] = 0; m_junc[k] = 0;
            end else begin
                case (m_st[k])
                    0: if (start) m_st[k] = 1;
                    1: begin
                        m_dir[k]  = pick(det, k == 1);
                        m_junc[k] = (n_clear(det) >= 2);
                        if (m_junc[k] && m_jc[k] < m_jmax[k]) m_jc[k]++;
                        m_st[k] = 2;
                    end
                    2: if (cmd_ready) begin m_st[k] = 3; m_rem[k] = TO; end
                    3: begin
                        if (move_done) begin
                            m_st[k] = 4; m_rem[k] = BT;
                        end else if (TO != 0) begin
                            m_rem[k]--;
                            if (m_rem[k] == 0) m_st[k] = 6;
                        end
                    end
                    4: begin
                        m_rem[k]--;
                        if (m_rem[k] == 0) begin m_st[k] = 5; m_rem[k] = FT; m_first[k] = 1; end
                    end
                    5: begin
                        m_first[k] = 0;
                        m_rem[k]--;
                        if (m_rem[k] == 0) m_st[k] = 1;
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic cmp(input int k, input logic [3:0] st, input logic v, input logic [1:0] dir,
                       input logic fw, input logic bw, input logic bar, input logic flt,
                       input int jc);
        bit ebar;
`ifdef AUTO_BARRIER_EN
        ebar = (m_st[k] == 5) && m_first[k] && m_junc[k];
`else
        ebar = 1'b0;
`endif
        checks++;
        if (int'(st) != m_st[k] || v != (m_st[k] == 2) || int'(dir) != m_dir[k] ||
            fw != (m_st[k] == 5) || bw != (m_st[k] == 4) || bar != ebar ||
            flt != (m_st[k] == 6) || jc != m_jc[k]) begin
            errors++;
            $display("FAIL model[%0d] t=%0t got st=%0d v=%b dir=%0d fw=%b bw=%b bar=%b flt=%b jc=%0d exp st=%0d dir=%0d bar=%b jc=%0d",
                     k, $time, st, v, dir, fw, bw, bar, flt, jc, m_st[k], m_dir[k], ebar, m_jc[k]);
        end
    endtask

    always @(posedge clk or posedge rst) model_tick();

    always @(negedge clk) begin
        cmp(0, s0, v0, d0, f0, b0, p0, fl0, int'(j0));
        cmp(1, s1, v1, d1, f1, b1, p1, fl1, int'(j1));
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
        end
    endtask

    task automatic wait_state(input int s, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (int'(s0) == s) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_state t=%0t got=%0d exp=%0d (timeout)", $time, s0, s);
    endtask

    task automatic pulse_done();
        move_done = 1'b1;
        @(negedge clk);
        move_done = 1'b0;
    endtask

    initial begin
        int nb, nf;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_state", int'(s0), 0);
        chk("reset_dir", int'(d0), 0);
        rst = 1'b0;

        // Open space, ready high, done 3 cycles after transfer
        start = 1'b1; det = 4'b0000; cmd_ready = 1'b1;
        wait_state(3, 10);
        repeat (2) @(negedge clk);
        move_done = 1'b1;
        @(negedge clk);
        move_done = 1'b0;
        nb = 0; nf = 0;
        for (int i = 0; i < 40 && s0 != 4'd1; i++) begin
            nb += int'(b0);
            nf += int'(f0);
            @(negedge clk);
        end
        chk("back_cycles", nb, 4);
        chk("fwd_cycles", nf, 2);
        chk("loop_to_decide", int'(s0), 1);
        chk("rh_open_dir", int'(d0), 2);
        chk("lh_open_dir", int'(d1), 1);
        chk("jcnt_first", int'(j0), 1);

        // Front and right blocked; ready withheld 5 cycles
        det = 4'b1001; cmd_ready = 1'b0;
        wait_state(2, 5);
        repeat (5) @(negedge clk);
        chk("hold_valid", int'(v0), 1);
        chk("hold_dir", int'(d0), 1);
        cmd_ready = 1'b1;
        @(negedge clk);
        chk("moving_after_ready", int'(s0), 3);
        pulse_done();

        // Everything blocked -> back, not a junction; then let the watchdog fire
        wait_state(1, 20);
        det = 4'b1011;
        wait_state(3, 10);
        chk("blocked_dir", int'(d0), 3);
        chk("blocked_jcnt", int'(j0), 1);
        wait_state(6, 20);
        chk("fault_flag", int'(fl0), 1);
        enable = 1'b0;
        @(negedge clk);
        chk("fault_clear", int'(s0), 0);
        enable = 1'b1; det = 4'b0000;

        // move_done in the 10th MOVING cycle beats the watchdog
        wait_state(3, 10);
        repeat (9) @(negedge clk);
        pulse_done();
        chk("done_beats_wd", int'(s0), 4);

        // Async reset mid-BACKING
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_state", int'(s0), 0);
        chk("rst_async_outs", int'({v0, f0, b0, p0, fl0, d0}), 0);
        chk("rst_async_jcnt", int'(j0), 0);
        det = 4'b0001;
        @(negedge clk);
        rst = 1'b0;

        // Junction decision -> barrier pulse (when enabled); disable mid-FORWARD
        wait_state(3, 10);
        pulse_done();
        wait_state(5, 20);
`ifdef AUTO_BARRIER_EN
        chk("barrier_pulse", int'(p0), 1);
`else
        chk("barrier_pulse", int'(p0), 0);
`endif
        enable = 1'b0;
        @(negedge clk);
        chk("disable_idle", int'(s0), 0);
        chk("disable_jcnt", int'(j0), 1);
        enable = 1'b1; det = 4'b1011;
        wait_state(3, 10);
        pulse_done();
        wait_state(5, 20);
        chk("no_barrier", int'(p0), 0);

        // Three more junctions: 2-bit counter saturates
        for (int n = 0; n < 3; n++) begin
            wait_state(1, 20);
            det = 4'b0000;
            wait_state(3, 10);
            pulse_done();
        end
        chk("jcnt_rh", int'(j0), 4);
        chk("jcnt_sat", int'(j1), 3);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
